// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory port: FSM states, request kinds,
// data width and the wait-state limit.
package mem_port_pkg;

  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    REQ_RD,
    REQ_WR
  } req_t;

endpackage

// File: rtl/mem_port_if.sv
// Control-unit side of the memory port: bus value, load strobes, access
// strobes, and the MAR/MDR/status values returned to the datapath.
interface mem_port_if #(
  parameter int ADDR_W = 9
);
  import mem_port_pkg::*;

  logic [DATA_W-1:0] BusMuxOut;
  logic              MARIn;
  logic              MDRIn;
  logic              Read;
  logic              Write;
  logic [ADDR_W-1:0] MAR_q;
  logic [DATA_W-1:0] MDR_q;
  logic              Mem_Ready;
  logic              Mem_Busy;
  logic              Mem_Err;

  modport master (
    output BusMuxOut, MARIn, MDRIn, Read, Write,
    input  MAR_q, MDR_q, Mem_Ready, Mem_Busy, Mem_Err
  );

  modport slave (
    input  BusMuxOut, MARIn, MDRIn, Read, Write,
    output MAR_q, MDR_q, Mem_Ready, Mem_Busy, Mem_Err
  );

endinterface

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with a registered read port (read-first).
// Contents are deliberately not reset.
module ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_port_unit.sv
// Memory port: MAR, MDR and main RAM, executing Read/Write strobes with a
// fixed number of wait states and reporting completion through Mem_Ready.
module mem_port_unit
  import mem_port_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1
) (
  input logic       Clock,
  input logic       Reset,
  mem_port_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t            state;
  req_t              req;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ready;
  logic              busy;
  logic              err;

  // In IDLE the RAM looks at the live MAR, so with zero wait states the read
  // word is already registered by the time the access commits.
  assign ram_addr = (state == IDLE) ? mar : lat_addr;
  assign ram_we   = (state == ACCESS) && (cnt == '0) && (req == REQ_WR);

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .Clock (Clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (lat_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      req      <= REQ_RD;
      cnt      <= '0;
      mar      <= '0;
      lat_addr <= '0;
      mdr      <= '0;
      lat_data <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (bus.MARIn) mar <= bus.BusMuxOut[ADDR_W-1:0];
      if (bus.MDRIn && (state == IDLE) && !bus.Read) mdr <= bus.BusMuxOut;

      case (state)
        IDLE: begin
          if (bus.Read && bus.Write) begin
            err <= 1'b1;
          end else if (bus.Read || bus.Write) begin
            req      <= bus.Write ? REQ_WR : REQ_RD;
            lat_addr <= mar;
            lat_data <= mdr;
            cnt      <= WAIT_INIT;
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (req == REQ_RD) mdr <= ram_rdata;
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // A held strobe parks here so it can never start a second access.
          if (!bus.Read && !bus.Write) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MAR_q     = mar;
  assign bus.MDR_q     = mdr;
  assign bus.Mem_Ready = ready;
  assign bus.Mem_Busy  = busy;
  assign bus.Mem_Err   = err;

endmodule

// File: tb/tb_mem_port_unit.sv
// Scoreboard bench for mem_port_unit: five instances with different wait
// states, random traffic against a word-array model, per-instance monitors.
module tb_mem_port_unit;
  import mem_port_pkg::*;

  localparam int NI     = 5;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  function automatic int wait_of(int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      3:       return 15;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    logic [31:0] mdr;
    int          req_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] bus_v  [NI];
  logic        mar_in [NI];
  logic        mdr_in [NI];
  logic        rd     [NI];
  logic        wr     [NI];
  logic        rst    [NI];

  wire  [ADDR_W-1:0] mar_q [NI];
  wire  [31:0]       mdr_q [NI];
  wire               rdy   [NI];
  wire               bsy   [NI];
  wire               err   [NI];

  exp_t        exp_q [NI][$];
  logic [31:0] mem_m [NI][DEPTH];
  logic [31:0] mdr_m [NI];
  logic [8:0]  mar_m [NI];

  task automatic checkOutput(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s inst%0d: got 0x%08h, expected 0x%08h", name, i, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = wait_of(g);

    mem_port_if #(.ADDR_W(ADDR_W)) bif ();

    assign bif.BusMuxOut = bus_v[g];
    assign bif.MARIn     = mar_in[g];
    assign bif.MDRIn     = mdr_in[g];
    assign bif.Read      = rd[g];
    assign bif.Write     = wr[g];
    assign mar_q[g]      = bif.MAR_q;
    assign mdr_q[g]      = bif.MDR_q;
    assign rdy[g]        = bif.Mem_Ready;
    assign bsy[g]        = bif.Mem_Busy;
    assign err[g]        = bif.Mem_Err;

    mem_port_unit #(
      .ADDR_W      (ADDR_W),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (W)
    ) dut (
      .Clock (clk),
      .Reset (rst[g]),
      .bus   (bif.slave)
    );

    // Each rising Mem_Ready retires one queued access: latency, busy span, MDR.
    initial begin : mon
      logic prev_rdy;
      int   busy_cnt;
      exp_t e;
      prev_rdy = 1'b0;
      busy_cnt = 0;
      forever begin
        @(negedge clk);
        if (rst[g]) begin
          prev_rdy = 1'b0;
          busy_cnt = 0;
        end else begin
          if (bsy[g]) busy_cnt++;
          if (rdy[g] && !prev_rdy) begin
            if (exp_q[g].size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("[TB] FAIL unexpected_ready inst%0d: got ready with empty queue, expected none", g);
            end else begin
              e = exp_q[g].pop_front();
              checkOutput("latency_edges", g, cyc - e.req_cyc + 1, W + 2);
              checkOutput("busy_cycles", g, busy_cnt, W + 1);
              checkOutput("mdr_after_access", g, mdr_q[g], e.mdr);
            end
            busy_cnt = 0;
          end
          prev_rdy = rdy[g];
        end
      end
    end
  end

  task automatic setMar(int i, logic [31:0] v);
    bus_v[i]  = v;
    mar_in[i] = 1'b1;
    @(negedge clk);
    mar_in[i] = 1'b0;
    mar_m[i]  = v[8:0];
  endtask

  task automatic setMdr(int i, logic [31:0] v);
    bus_v[i]  = v;
    mdr_in[i] = 1'b1;
    @(negedge clk);
    mdr_in[i] = 1'b0;
    mdr_m[i]  = v;
  endtask

  task automatic checkResetState(int i);
    checkOutput("reset_mar", i, 32'(mar_q[i]), 0);
    checkOutput("reset_mdr", i, mdr_q[i], 0);
    checkOutput("reset_ready", i, 32'(rdy[i]), 0);
    checkOutput("reset_busy", i, 32'(bsy[i]), 0);
    checkOutput("reset_err", i, 32'(err[i]), 0);
  endtask

  // One complete access from IDLE back to IDLE; the expectation is queued
  // before the strobe is sampled.
  task automatic applyStimulus(int i, bit is_wr, int hold, bit mar_change, logic [31:0] new_mar);
    exp_t e;
    int   n;
    if (is_wr) mem_m[i][mar_m[i]] = mdr_m[i];
    else       mdr_m[i] = mem_m[i][mar_m[i]];
    e.mdr     = mdr_m[i];
    e.req_cyc = cyc + 1;
    exp_q[i].push_back(e);
    rd[i] = !is_wr;
    wr[i] = is_wr;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (mar_change && n == 1) begin
        bus_v[i]  = new_mar;
        mar_in[i] = 1'b1;
        mar_m[i]  = new_mar[8:0];
      end else begin
        mar_in[i] = 1'b0;
      end
      if (rdy[i] || n > 40) break;
    end
    checkOutput("ready_seen", i, 32'(rdy[i]), 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("ready_held", i, 32'(rdy[i]), 1);
    end
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    @(negedge clk);
    checkOutput("ready_drop", i, 32'(rdy[i]), 0);
    checkOutput("busy_idle", i, 32'(bsy[i]), 0);
  endtask

  task automatic pulseReset(int i);
    rst[i] = 1'b1;
    rd[i]  = 1'b0;
    wr[i]  = 1'b0;
    #1;
    checkResetState(i);
    @(negedge clk);
    @(negedge clk);
    rst[i]   = 1'b0;
    mdr_m[i] = '0;
    mar_m[i] = '0;
  endtask

  task automatic randomTraffic(int i, int n);
    logic [8:0] pool [8];
    logic [8:0] a;
    pool = '{9'h000, 9'h001, 9'h07F, 9'h0AA, 9'h100, 9'h155, 9'h1FE, 9'h1FF};
    for (int k = 0; k < 8; k++) begin
      setMar(i, {23'($urandom), pool[k]});
      setMdr(i, $urandom);
      applyStimulus(i, 1'b1, 0, 1'b0, '0);
    end
    for (int k = 0; k < n; k++) begin
      a = pool[$urandom_range(0, 7)];
      setMar(i, 32'(a));
      setMdr(i, $urandom);
      applyStimulus(i, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, '0);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    for (int i = 0; i < NI; i++) begin
      bus_v[i] = '0; mar_in[i] = 1'b0; mdr_in[i] = 1'b0;
      rd[i] = 1'b0; wr[i] = 1'b0; rst[i] = 1'b1;
      mdr_m[i] = '0; mar_m[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) checkResetState(i);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    @(negedge clk);

    // Write then read back at WAIT_CYCLES=1.
    setMar(0, 32'h0000_0055);
    setMdr(0, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b1, 0, 1'b0, '0);
    setMdr(0, 32'h0);
    applyStimulus(0, 1'b0, 0, 1'b0, '0);
    checkOutput("write_read_mdr", 0, mdr_q[0], 32'hDEAD_BEEF);

    // Read strobe held for ten cycles in total.
    applyStimulus(0, 1'b0, 7, 1'b0, '0);

    // MAR changes while the read is in flight.
    setMar(0, 32'h10); setMdr(0, 32'h1111_0010); applyStimulus(0, 1'b1, 0, 1'b0, '0);
    setMar(0, 32'h20); setMdr(0, 32'h2222_0020); applyStimulus(0, 1'b1, 0, 1'b0, '0);
    setMar(0, 32'h10);
    applyStimulus(0, 1'b0, 0, 1'b1, 32'h20);
    checkOutput("mid_access_mdr", 0, mdr_q[0], 32'h1111_0010);
    checkOutput("mid_access_mar", 0, 32'(mar_q[0]), 32'h20);

    // Read and Write together in IDLE.
    setMar(0, 32'h55);
    setMdr(0, 32'hBAD0_BAD0);
    rd[0] = 1'b1; wr[0] = 1'b1;
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b0;
    checkOutput("err_set", 0, 32'(err[0]), 1);
    checkOutput("err_busy", 0, 32'(bsy[0]), 0);
    checkOutput("err_ready", 0, 32'(rdy[0]), 0);
    checkOutput("err_mdr", 0, mdr_q[0], 32'hBAD0_BAD0);
    @(negedge clk);
    checkOutput("err_stays_idle", 0, 32'(bsy[0]), 0);
    applyStimulus(0, 1'b0, 0, 1'b0, '0);
    checkOutput("err_ram_unchanged", 0, mdr_q[0], 32'hDEAD_BEEF);
    checkOutput("err_sticky", 0, 32'(err[0]), 1);

    // Address wrap.
    setMar(0, 32'h0000_0200);
    checkOutput("mar_wrap", 0, 32'(mar_q[0]), 0);

    // Reset two cycles into a write with WAIT_CYCLES=4.
    setMar(4, 32'h1FF);
    setMdr(4, 32'hCAFE_F00D);
    applyStimulus(4, 1'b1, 0, 1'b0, '0);
    setMdr(4, 32'h1234_5678);
    wr[4] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pulseReset(4);
    @(negedge clk);
    checkResetState(4);
    setMar(4, 32'h1FF);
    applyStimulus(4, 1'b0, 0, 1'b0, '0);
    checkOutput("abort_keeps_old", 4, mdr_q[4], 32'hCAFE_F00D);

    // Random traffic on every wait-state setting.
    randomTraffic(0, 30);
    randomTraffic(1, 10);
    randomTraffic(2, 8);
    randomTraffic(3, 5);
    randomTraffic(4, 5);

    checkOutput("err_before_reset", 0, 32'(err[0]), 1);
    pulseReset(0);
    @(negedge clk);
    checkOutput("err_cleared", 0, 32'(err[0]), 0);

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) checkOutput("queue_drained", i, exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
